// File: rtl/clock_divider_ctrl.sv
// Programmable slow-clock generator with glitch-free divisor reload and run/halt gating.
// Define CLKDIV_STEP_EN to add the single-period debug step input (i_step_req).
module clock_divider_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEFAULT_HALF = 64
) (
  input  logic             i_fastclk,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic             i_div_load,
  input  logic [CNT_W-1:0] i_div_value,
`ifdef CLKDIV_STEP_EN
  input  logic             i_step_req,
`endif
  output logic             o_slowclk,
  output logic             o_slow_rise,
  output logic             o_slow_fall,
  output logic             o_load_busy,
  output logic             o_load_done
);

  localparam logic [CNT_W-1:0] HalfRst = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] One     = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_pending;
  logic             r_slowclk;
  logic             r_slow_rise;
  logic             r_slow_fall;
  logic             r_load_busy;
  logic             r_load_done;

  logic             w_active;
  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_half_m1;
  logic [CNT_W-1:0] w_div_sat;

`ifdef CLKDIV_STEP_EN
  logic r_step_active;

  assign w_active = i_run | r_slowclk | r_step_active;

  // A step may only start from full idle; it ends with its own falling toggle.
  always_ff @(posedge i_fastclk or posedge i_reset) begin
    if (i_reset) begin
      r_step_active <= 1'b0;
    end else if (!w_active && i_step_req) begin
      r_step_active <= 1'b1;
    end else if (w_wrap && r_slowclk) begin
      r_step_active <= 1'b0;
    end
  end
`else
  assign w_active = i_run | r_slowclk;
`endif

  assign w_half_m1 = r_half - One;
  assign w_wrap    = w_active && (r_cnt == w_half_m1);
  // Divisor swaps only where no phase is in progress, so duty cycle is never broken.
  assign w_apply   = !w_active || (w_wrap && r_slowclk);
  assign w_div_sat = (i_div_value == '0) ? One : i_div_value;

  always_ff @(posedge i_fastclk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_half      <= HalfRst;
      r_pending   <= HalfRst;
      r_slowclk   <= 1'b0;
      r_slow_rise <= 1'b0;
      r_slow_fall <= 1'b0;
      r_load_busy <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_slow_rise <= w_wrap & ~r_slowclk;
      r_slow_fall <= w_wrap & r_slowclk;
      r_load_done <= 1'b0;

      if (!w_active) begin
        r_cnt     <= '0;
        r_slowclk <= 1'b0;
      end else if (w_wrap) begin
        r_cnt     <= '0;
        r_slowclk <= ~r_slowclk;
      end else begin
        r_cnt     <= r_cnt + One;
      end

      if (r_load_busy && w_apply) begin
        r_half      <= r_pending;
        r_load_busy <= 1'b0;
        r_load_done <= 1'b1;
      end else if (i_div_load && !r_load_busy) begin
        r_pending   <= w_div_sat;
        r_load_busy <= 1'b1;
      end
    end
  end

  assign o_slowclk   = r_slowclk;
  assign o_slow_rise = r_slow_rise;
  assign o_slow_fall = r_slow_fall;
  assign o_load_busy = r_load_busy;
  assign o_load_done = r_load_done;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Scoreboard bench for clock_divider_ctrl: expected strobe edges are queued by the stimulus
// and matched by a monitor; the step scenario runs only when CLKDIV_STEP_EN is defined.
module tb_clock_divider_ctrl;

  localparam int unsigned CNT_W = 16;
  localparam logic [1:0] KRise = 2'd0;
  localparam logic [1:0] KFall = 2'd1;
  localparam logic [1:0] KDone = 2'd2;

  logic             clk;
  logic             rst;
  logic             run;
  logic             dl;
  logic [CNT_W-1:0] dv;
  logic             step;
  logic             o_slowclk, o_slow_rise, o_slow_fall, o_load_busy, o_load_done;

  typedef struct packed {
    int         edge_no;
    logic [1:0] kind;
  } ev_t;

  ev_t exp_q[$];
  int  edge_cnt = 0;
  int  n_checks = 0;
  int  n_err    = 0;
  int  k;
  int  s;

  clock_divider_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_HALF(64)
  ) dut (
    .i_fastclk  (clk),
    .i_reset    (rst),
    .i_run      (run),
    .i_div_load (dl),
    .i_div_value(dv),
`ifdef CLKDIV_STEP_EN
    .i_step_req (step),
`endif
    .o_slowclk  (o_slowclk),
    .o_slow_rise(o_slow_rise),
    .o_slow_fall(o_slow_fall),
    .o_load_busy(o_load_busy),
    .o_load_done(o_load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  function automatic string kname(input logic [1:0] kd);
    case (kd)
      KRise:   return "rise";
      KFall:   return "fall";
      default: return "done";
    endcase
  endfunction

  task automatic push(input int e, input logic [1:0] kd);
    ev_t ev;
    ev.edge_no = e;
    ev.kind    = kd;
    exp_q.push_back(ev);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic mon_hit(input logic [1:0] kd, input int cur);
    ev_t ev;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL strobe: got %s@%0d, expected none", kname(kd), cur);
    end else begin
      ev = exp_q.pop_front();
      if (ev.edge_no != cur || ev.kind != kd) begin
        n_err++;
        $display("FAIL strobe: got %s@%0d, expected %s@%0d",
                 kname(kd), cur, kname(ev.kind), ev.edge_no);
      end
    end
  endtask

  // Monitor: strobes sampled mid-cycle belong to the edge just passed.
  always @(negedge clk) begin
    int   cur;
    ev_t  ev;
    cur = edge_cnt - 1;
    while (exp_q.size() > 0 && exp_q[0].edge_no < cur) begin
      ev = exp_q.pop_front();
      n_checks++;
      n_err++;
      $display("FAIL strobe: got nothing, expected %s@%0d", kname(ev.kind), ev.edge_no);
    end
    if (o_slow_rise) begin
      mon_hit(KRise, cur);
      chk("slowclk_at_rise", {31'd0, o_slowclk}, 32'd1);
    end
    if (o_slow_fall) begin
      mon_hit(KFall, cur);
      chk("slowclk_at_fall", {31'd0, o_slowclk}, 32'd0);
    end
    if (o_load_done) mon_hit(KDone, cur);
  end

  task automatic wait_until(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  task automatic idle_load(input logic [CNT_W-1:0] v);
    int j;
    dl = 1'b1;
    dv = v;
    j  = edge_cnt;
    push(j + 1, KDone);
    @(negedge clk);
    chk("busy_after_capture", {31'd0, o_load_busy}, 32'd1);
    dl = 1'b0;
    @(negedge clk);
    chk("busy_after_idle_apply", {31'd0, o_load_busy}, 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {27'd0, o_slowclk, o_slow_rise, o_slow_fall, o_load_busy, o_load_done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; dl = 1'b0; dv = '0; step = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");

    // Default half 64 from reset.
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    k   = edge_cnt;
    push(k + 63, KRise);
    push(k + 127, KFall);
    wait_until(k + 131);
    run = 1'b0;
    wait_until(k + 135);

    // Half 4, then reload 2 mid high phase; applies at the falling toggle.
    idle_load(16'd4);
    run = 1'b1;
    k   = edge_cnt;
    push(k + 3, KRise);  push(k + 7, KFall);
    push(k + 11, KRise); push(k + 15, KFall); push(k + 15, KDone);
    push(k + 17, KRise); push(k + 19, KFall);
    push(k + 21, KRise); push(k + 23, KFall);
    wait_until(k + 13);
    dl = 1'b1;
    dv = 16'd2;
    @(negedge clk);
    chk("busy_mid_high", {31'd0, o_load_busy}, 32'd1);
    @(negedge clk);
    chk("busy_held", {31'd0, o_load_busy}, 32'd1);
    chk("still_high", {31'd0, o_slowclk}, 32'd1);
    @(negedge clk);
    chk("busy_cleared_at_fall", {31'd0, o_load_busy}, 32'd0);
    chk("low_after_fall", {31'd0, o_slowclk}, 32'd0);
    dl = 1'b0;
    wait_until(k + 25);
    run = 1'b0;
    wait_until(k + 30);

    // Zero divisor saturates to 1: fastclk/2.
    idle_load(16'd0);
    run = 1'b1;
    k   = edge_cnt;
    push(k, KRise); push(k + 1, KFall); push(k + 2, KRise); push(k + 3, KFall);
    wait_until(k + 4);
    run = 1'b0;
    wait_until(k + 8);

    // Halt one cycle into a 10-cycle high phase.
    idle_load(16'd10);
    run = 1'b1;
    k   = edge_cnt;
    push(k + 9, KRise);
    push(k + 19, KFall);
    wait_until(k + 11);
    run = 1'b0;
    wait_until(k + 19);
    chk("high_phase_completes", {31'd0, o_slowclk}, 32'd1);
    @(negedge clk);
    chk("low_after_halt", {31'd0, o_slowclk}, 32'd0);
    wait_until(k + 26);
    chk("stays_low_halted", {31'd0, o_slowclk}, 32'd0);

`ifdef CLKDIV_STEP_EN
    // One debug step at half 3; a second request mid-step is ignored.
    idle_load(16'd3);
    step = 1'b1;
    s    = edge_cnt;
    push(s + 3, KRise);
    push(s + 6, KFall);
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_until(s + 14);
    chk("step_idle_after", {31'd0, o_slowclk}, 32'd0);
`endif

    // Asynchronous reset while busy and high; half returns to 64.
    idle_load(16'd3);
    run = 1'b1;
    k   = edge_cnt;
    push(k + 2, KRise);
    wait_until(k + 4);
    dl = 1'b1;
    dv = 16'd5;
    @(negedge clk);
    chk("busy_before_reset", {31'd0, o_load_busy}, 32'd1);
    chk("high_before_reset", {31'd0, o_slowclk}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset_outputs");
    dl  = 1'b0;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    k   = edge_cnt;
    push(k + 63, KRise);
    push(k + 127, KFall);
    wait_until(k + 65);
    run = 1'b0;
    wait_until(k + 132);
    chk("low_after_reset_run", {31'd0, o_slowclk}, 32'd0);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_events: got %0d left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
